// File: rtl/prf_wb_queue.sv
`timescale 1ns/1ps
// prf_wb_queue: age-ordered writeback FIFO feeding the PRF write ports.
// Optional PRF_WBQ_BYPASS_EN: results skip the FIFO when it is empty.
module prf_wb_queue #(
  parameter int IN_PORTS  = 4,
  parameter int OUT_PORTS = 4,
  parameter int DEPTH     = 16,
  parameter int PRN_BITS  = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [IN_PORTS-1:0]                in_valid,
  input  logic [IN_PORTS-1:0][PRN_BITS-1:0]  in_prn,
  input  logic [IN_PORTS-1:0][63:0]          in_data,
  output logic                               in_ready,
  input  logic                               drain_en,
  output logic [OUT_PORTS-1:0]               wb_wen,
  output logic [OUT_PORTS-1:0][PRN_BITS-1:0] wb_wprn,
  output logic [OUT_PORTS-1:0][63:0]         wb_wdata,
  output logic [$clog2(DEPTH+1)-1:0]         count,
  output logic                               overflow_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NC = (IN_PORTS > OUT_PORTS) ? IN_PORTS : OUT_PORTS;

  logic [PRN_BITS-1:0] r_mprn  [DEPTH];
  logic [63:0]         r_mdata [DEPTH];
  logic [PW-1:0]       r_head;
  logic [PW-1:0]       r_tail;
  logic [CW-1:0]       r_count;
  logic                r_live;
  logic                r_ovf;

  logic [NC-1:0][PRN_BITS-1:0] w_cprn;
  logic [NC-1:0][63:0]         w_cdata;
  logic [CW-1:0]               w_k;
  logic [CW-1:0]               w_kacc;
  logic [CW-1:0]               w_n;
  logic [CW-1:0]               w_nbyp;
  logic [CW-1:0]               w_enq;
  logic                        w_rdy;
  int                          w_idx;

  // r_live keeps in_ready low until the first edge after reset release
  assign w_rdy = r_live &&
    ((CW'(DEPTH) - r_count) >= CW'(IN_PORTS));

  always_comb begin
    w_cprn  = '0;
    w_cdata = '0;
    w_idx   = 0;
    for (int i = 0; i < IN_PORTS; i++) begin
      if (in_valid[i]) begin
        w_cprn[w_idx]  = in_prn[i];
        w_cdata[w_idx] = in_data[i];
        w_idx          = w_idx + 1;
      end
    end
    w_k = CW'(w_idx);
  end

  assign w_kacc = w_rdy ? w_k : '0;
  assign w_n = !drain_en ? '0 :
    (r_count > CW'(OUT_PORTS)) ? CW'(OUT_PORTS) : r_count;

`ifdef PRF_WBQ_BYPASS_EN
  assign w_nbyp = (w_rdy && drain_en && r_count == '0) ?
    ((w_k > CW'(OUT_PORTS)) ? CW'(OUT_PORTS) : w_k) : '0;
`else
  assign w_nbyp = '0;
`endif

  assign w_enq = w_kacc - w_nbyp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_live   <= 1'b0;
      r_ovf    <= 1'b0;
      wb_wen   <= '0;
      wb_wprn  <= '0;
      wb_wdata <= '0;
    end else begin
      r_live  <= 1'b1;
      r_head  <= r_head + PW'(w_n);
      r_tail  <= r_tail + PW'(w_enq);
      r_count <= r_count + w_enq - w_n;
      if (|in_valid && !w_rdy) r_ovf <= 1'b1;
      for (int j = 0; j < OUT_PORTS; j++) begin
        wb_wen[j] <= (CW'(j) < w_n) || (CW'(j) < w_nbyp);
        if (CW'(j) < w_n) begin
          wb_wprn[j]  <= r_mprn[r_head + PW'(j)];
          wb_wdata[j] <= r_mdata[r_head + PW'(j)];
        end else if (CW'(j) < w_nbyp) begin
          wb_wprn[j]  <= w_cprn[j];
          wb_wdata[j] <= w_cdata[j];
        end
      end
    end
  end

  // compacted results past the bypassed ones land at tail onward
  always_ff @(posedge clk) begin
    for (int m = 0; m < NC; m++) begin
      if (CW'(m) >= w_nbyp && CW'(m) < w_kacc) begin
        r_mprn[r_tail + PW'(m) - PW'(w_nbyp)]  <= w_cprn[m];
        r_mdata[r_tail + PW'(m) - PW'(w_nbyp)] <= w_cdata[m];
      end
    end
  end

  assign in_ready     = w_rdy;
  assign count        = r_count;
  assign overflow_err = r_ovf;

endmodule
